// File: rtl/line_buffer.sv
// line_buffer: vertical sliding-window line buffer for streaming video.
// Produces, for every active input pixel, the column vector of the current
// line plus the M_DEPTH-1 lines above it. Output is 2 cycles after input.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   pixel_i         pixel sample, qualified by dv_i
//   dv_i/hs_i/vs_i  data valid / horizontal sync / vertical sync
//   vect_o          column vector, vect_o[0] = current line, [k] = k lines up
//   dv_o/hs_o/vs_o  syncs delayed to align with vect_o
//   line_end_o      1-cycle pulse on the cycle after the last dv_o of a line
//   ovf_o           sticky: a line exceeded MAX_WIDTH in this frame
module line_buffer #(
    parameter int COLORDEPTH = 8,
    parameter int M_DEPTH    = 5,
    parameter int MAX_WIDTH  = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [COLORDEPTH-1:0]                 pixel_i,
    input  logic                                  dv_i,
    input  logic                                  hs_i,
    input  logic                                  vs_i,
    output logic [M_DEPTH-1:0][COLORDEPTH-1:0]    vect_o,
    output logic                                  dv_o,
    output logic                                  hs_o,
    output logic                                  vs_o,
    output logic                                  line_end_o,
    output logic                                  ovf_o
);

    localparam int CW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int RW = (M_DEPTH > 1) ? $clog2(M_DEPTH) : 1;
    localparam int NM = M_DEPTH - 1;
    localparam logic [CW-1:0] COL_LAST = CW'(MAX_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(M_DEPTH - 1);

    typedef logic [COLORDEPTH-1:0] pix_t;

    // input-side counters
    logic [CW-1:0] col_q, col_d;
    logic          full_q, full_d;     // last legal column already taken
    logic [RW-1:0] row_q, row_d;

    // stage 1: aligned with the synchronous memory read
    logic          dv1_q, dv1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic          ovf1_q, ovf1_d;
    logic          wr_en_q, wr_en_d;
    logic [CW-1:0] wr_addr_q, wr_addr_d;
    logic [RW-1:0] row1_q, row1_d;
    pix_t          pix1_q, pix1_d;

    // stage 2: outputs
    logic [M_DEPTH-1:0][COLORDEPTH-1:0] vect_q, vect_d;
    logic          dv2_q, dv2_d, hs2_q, hs2_d, vs2_q, vs2_d;
    logic          line_end_q, line_end_d;
    logic          ovf_q, ovf_d;

    pix_t rd_w    [NM];
    pix_t wdata_w [NM];

    // Line memories. The write of a pixel is deferred by one cycle and uses
    // the tap read for that same column, so memory k receives the old value
    // of memory k-1 (read-before-write cascade) without a combinational read.
    // Consecutive cycles never share a written column, so the deferral
    // cannot collide with a read.
    for (genvar g = 0; g < NM; g++) begin : g_mem
        pix_t mem [MAX_WIDTH];
        pix_t rd_q;

        if (g == 0) begin : g_first
            assign wdata_w[g] = pix1_q;
        end else begin : g_casc
            assign wdata_w[g] = rd_w[g-1];
        end

        always_ff @(posedge clk) begin
            if (dv_i)    rd_q            <= mem[col_q];
            if (wr_en_q) mem[wr_addr_q]  <= wdata_w[g];
        end

        assign rd_w[g] = rd_q;
    end

    always_comb begin
        col_d  = '0;
        full_d = 1'b0;
        if (dv_i) begin
            col_d  = (col_q == COL_LAST) ? col_q : col_q + 1'b1;
            full_d = full_q | (col_q == COL_LAST);
        end

        // vs rising edge beats a dv falling edge in the same cycle
        row_d = row_q;
        if (vs_i && !vs1_q)
            row_d = '0;
        else if (dv1_q && !dv_i && row_q != ROW_LAST)
            row_d = row_q + 1'b1;

        dv1_d     = dv_i;
        hs1_d     = hs_i;
        vs1_d     = vs_i;
        pix1_d    = dv_i ? pixel_i : pix1_q;
        row1_d    = row_q;
        ovf1_d    = dv_i & full_q;
        wr_en_d   = dv_i & ~full_q;
        wr_addr_d = col_q;
    end

    always_comb begin
        vect_d = vect_q;
        if (dv1_q) begin
            vect_d[0] = pix1_q;
            // zero-pad taps above the top of the frame and for overflow pixels
            for (int k = 1; k < M_DEPTH; k++)
                vect_d[k] = (!ovf1_q && int'(row1_q) >= k) ? rd_w[k-1] : '0;
        end

        dv2_d      = dv1_q;
        hs2_d      = hs1_q;
        vs2_d      = vs1_q;
        line_end_d = dv2_q & ~dv1_q;

        // set wins over clear when both land on the same cycle
        ovf_d = ovf_q;
        if (vs1_q && !vs2_q) ovf_d = 1'b0;
        if (dv1_q && ovf1_q) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q      <= '0;
            full_q     <= 1'b0;
            row_q      <= '0;
            dv1_q      <= 1'b0;
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            ovf1_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            row1_q     <= '0;
            pix1_q     <= '0;
            vect_q     <= '0;
            dv2_q      <= 1'b0;
            hs2_q      <= 1'b0;
            vs2_q      <= 1'b0;
            line_end_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            col_q      <= col_d;
            full_q     <= full_d;
            row_q      <= row_d;
            dv1_q      <= dv1_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            ovf1_q     <= ovf1_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            row1_q     <= row1_d;
            pix1_q     <= pix1_d;
            vect_q     <= vect_d;
            dv2_q      <= dv2_d;
            hs2_q      <= hs2_d;
            vs2_q      <= vs2_d;
            line_end_q <= line_end_d;
            ovf_q      <= ovf_d;
        end
    end

    assign vect_o     = vect_q;
    assign dv_o       = dv2_q;
    assign hs_o       = hs2_q;
    assign vs_o       = vs2_q;
    assign line_end_o = line_end_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_line_buffer.sv
// Scoreboard bench for line_buffer. The driver keeps a per-column history of
// written pixels plus row/overflow bookkeeping and pushes expected outputs;
// the monitor pops and compares whenever the DUT presents data.
module tb_line_buffer;

    localparam int CD = 8;
    localparam int MD = 5;
    localparam int MW = 16;

    typedef logic [MD-1:0][CD-1:0] vec_t;
    typedef struct { vec_t v; bit tag; } pexp_t;
    typedef struct { bit dv; bit hs; bit vs; bit le; bit ovf; } cexp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CD-1:0] pixel_i = '0;
    logic          dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
    vec_t          vect_o;
    logic          dv_o, hs_o, vs_o, line_end_o, ovf_o;

    line_buffer #(.COLORDEPTH(CD), .M_DEPTH(MD), .MAX_WIDTH(MW)) dut (
        .clk(clk), .rst(rst), .pixel_i(pixel_i), .dv_i(dv_i), .hs_i(hs_i),
        .vs_i(vs_i), .vect_o(vect_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
        .line_end_o(line_end_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // reference model state
    logic [CD-1:0] hist [MW][$];
    int    row_m = 0, col_m = 0;
    bit    prev_dv_m = 0, prev_vs_m = 0, ovf_m = 0;
    pexp_t pq[$];
    cexp_t cq[$];
    vec_t  last_v = '0;
    vec_t  tag_v;

    // one input cycle: drive, then derive the expected outputs from the rules
    task automatic drive(input bit dv, input bit hs, input bit vs,
                         input logic [CD-1:0] pix, input bit tag = 0);
        pexp_t pe;
        cexp_t ce;
        @(negedge clk);
        dv_i = dv; hs_i = hs; vs_i = vs; pixel_i = pix;
        if (vs && !prev_vs_m) ovf_m = 0;
        if (dv) begin
            pe.v   = '0;
            pe.v[0] = pix;
            pe.tag = tag;
            if (col_m < MW) begin
                for (int k = 1; k < MD; k++)
                    if (k <= row_m && hist[col_m].size() >= k)
                        pe.v[k] = hist[col_m][k-1];
                hist[col_m].push_front(pix);
                if (hist[col_m].size() > MD-1) void'(hist[col_m].pop_back());
            end else begin
                ovf_m = 1;
            end
            col_m++;
            pq.push_back(pe);
        end else begin
            col_m = 0;
        end
        ce.dv = dv; ce.hs = hs; ce.vs = vs;
        ce.le = prev_dv_m & !dv;
        ce.ovf = ovf_m;
        cq.push_back(ce);
        if (vs && !prev_vs_m) row_m = 0;
        else if (prev_dv_m && !dv && row_m < MD-1) row_m++;
        prev_dv_m = dv;
        prev_vs_m = vs;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        dv_i = 0; hs_i = 0; vs_i = 0; pixel_i = '0;
        #1;
        chk(vect_o === '0,     "rst_vect", 64'(vect_o), 0);
        chk(dv_o === 1'b0,     "rst_dv",   64'(dv_o), 0);
        chk(hs_o === 1'b0,     "rst_hs",   64'(hs_o), 0);
        chk(vs_o === 1'b0,     "rst_vs",   64'(vs_o), 0);
        chk(line_end_o === 1'b0, "rst_le", 64'(line_end_o), 0);
        chk(ovf_o === 1'b0,    "rst_ovf",  64'(ovf_o), 0);
        pq.delete(); cq.delete();
        for (int c = 0; c < MW; c++) hist[c].delete();
        row_m = 0; col_m = 0; prev_dv_m = 0; prev_vs_m = 0; ovf_m = 0;
        last_v = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic vs_pulse();
        drive(0, 0, 1, '0);
        drive(0, 0, 0, '0);
    endtask

    // 4 lines x 8 pixels, value 16*line+col, 1-cycle gaps; optional abort
    task automatic frame_a(input int stop_line, input int stop_col, output bit aborted);
        aborted = 0;
        for (int l = 0; l < 4; l++) begin
            for (int c = 0; c < 8; c++) begin
                if (l == stop_line && c == stop_col) begin
                    aborted = 1;
                    return;
                end
                drive(1, 0, 0, 8'(16*l + c), (l == 3 && c == 2));
            end
            drive(0, 1, 0, '0);
        end
    endtask

    task automatic rline(input int w, input int gap);
        for (int c = 0; c < w; c++) drive(1, 1'($urandom % 2), 0, 8'($urandom));
        for (int g = 0; g < gap; g++) drive(0, 1'($urandom % 2), 0, '0);
    endtask

    // monitor
    pexp_t mp;
    cexp_t mc;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            if (cq.size() == 2) begin
                mc = cq.pop_front();
                chk({dv_o, hs_o, vs_o, line_end_o, ovf_o} === {mc.dv, mc.hs, mc.vs, mc.le, mc.ovf},
                    "ctl(dv,hs,vs,le,ovf)",
                    64'({dv_o, hs_o, vs_o, line_end_o, ovf_o}),
                    64'({mc.dv, mc.hs, mc.vs, mc.le, mc.ovf}));
            end
            if (dv_o) begin
                if (pq.size() == 0) begin
                    chk(0, "unexpected_dv_o", 64'(dv_o), 0);
                end else begin
                    mp = pq.pop_front();
                    chk(vect_o === mp.v, "vect", 64'(vect_o), 64'(mp.v));
                    if (mp.tag) chk(vect_o === tag_v, "vect_l3c2", 64'(vect_o), 64'(tag_v));
                    last_v = mp.v;
                end
            end else begin
                chk(vect_o === last_v, "vect_hold", 64'(vect_o), 64'(last_v));
            end
        end
    end

    initial begin
        bit ab;
        tag_v = 40'h00_02_12_22_32;
        do_reset();

        // directed frame, back-to-back lines with 1-cycle gaps
        vs_pulse();
        frame_a(-1, 0, ab);
        repeat (2) drive(0, 0, 0, '0);

        // reset asserted at column 4 of line 2, then the same frame again
        vs_pulse();
        frame_a(2, 4, ab);
        do_reset();
        frame_a(-1, 0, ab);
        repeat (2) drive(0, 0, 0, '0);

        // overflow frame: 6 lines, the third is MAX_WIDTH+3 long
        vs_pulse();
        rline(MW, 2);
        rline(MW, 1);
        rline(MW + 3, 2);
        rline(MW, 1);
        rline(MW, 3);
        rline(MW, 2);
        vs_pulse();
        rline(MW, 2);

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            int w, nl;
            w  = int'($urandom_range(1, MW));
            nl = int'($urandom_range(1, 7));
            vs_pulse();
            for (int l = 0; l < nl; l++) rline(w, int'($urandom_range(1, 4)));
        end

        repeat (4) drive(0, 0, 0, '0);
        chk(pq.size() == 0, "drain", 64'(pq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
